// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 8;
    localparam int DMEM_DATA_W  = 8;
    localparam int DMEM_LATENCY = 5;
    localparam int DMEM_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/data_memory_responder_if.sv
// CPU <-> data-memory request/response bus.
// The CPU side is the master and the memory side is the slave.
interface data_memory_responder_if #(
    parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
    parameter int DATA_W = dmem_pkg::DMEM_DATA_W
);
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] WRITEDATA;
    logic [DATA_W-1:0] READDATA;
    logic              BUSYWAIT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );
endinterface

// File: rtl/dmem_array.sv
// Storage array with a synchronous write port, an asynchronous clear,
// and a registered read port that only updates when enabled.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_q
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;

    // Storage words: cleared on reset, written on an enabled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // The read register holds its value unless a read is being performed.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the CPU data-memory interface: accepts a read or write,
// stalls the CPU for a fixed number of edges, then performs the access.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    data_memory_responder_if.slave  bus
);
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    op_read_q, op_read_d;

    logic                    req;
    logic                    busy;
    logic                    mem_we;
    logic                    mem_re;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;

    assign req = bus.READ | bus.WRITE;

    // Stall is forced low while reset is held so the CPU is released at once.
    assign bus.BUSYWAIT = busy & ~RESET;

    // Next-state, request latch, latency counter and array access strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        op_read_d = op_read_q;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        case (state_q)
            IDLE: begin
                busy = req;
                if (req) begin
                    addr_d    = bus.ADDRESS;
                    data_d    = bus.WRITEDATA;
                    op_read_d = bus.READ;
                    if (LATENCY == 1) begin
                        mem_addr  = bus.ADDRESS;
                        mem_wdata = bus.WRITEDATA;
                        mem_re    = bus.READ;
                        mem_we    = ~bus.READ;
                        cnt_d     = '0;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    mem_re  = op_read_q;
                    mem_we  = ~op_read_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and request latch.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            op_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            op_read_q <= op_read_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (CLOCK),
        .rst     (RESET),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata_q (bus.READDATA)
    );
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder at LATENCY=5 and LATENCY=1.
module tb_data_memory_responder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    data_memory_responder_if #(.ADDR_W(8), .DATA_W(8)) bus5 ();
    data_memory_responder_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(5)) dut5 (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus5)
    );

    data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_bus(input int which, input logic rd, input logic wr,
                             input logic [7:0] a, input logic [7:0] d);
        if (which == 1) begin
            bus1.READ = rd; bus1.WRITE = wr; bus1.ADDRESS = a; bus1.WRITEDATA = d;
        end else begin
            bus5.READ = rd; bus5.WRITE = wr; bus5.ADDRESS = a; bus5.WRITEDATA = d;
        end
    endtask

    function automatic logic get_busy(input int which);
        return (which == 1) ? bus1.BUSYWAIT : bus5.BUSYWAIT;
    endfunction

    function automatic logic [7:0] get_rdata(input int which);
        return (which == 1) ? bus1.READDATA : bus5.READDATA;
    endfunction

    // Drive one request at a falling edge and count cycles with BUSYWAIT high.
    // Returns in the DONE cycle; the request is dropped unless hold is set.
    task automatic issue(input int which, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d,
                         input bit hold, input bit toggle,
                         output int busy_cycles, output logic first_busy,
                         output logic [7:0] rdata);
        @(negedge clk);
        drive_bus(which, rd, wr, a, d);
        #1;
        first_busy  = get_busy(which);
        busy_cycles = 0;
        while (get_busy(which) === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
            if (toggle && busy_cycles == 1) begin
                drive_bus(which, rd, wr, 8'hFF, 8'h01);
            end
            #1;
        end
        rdata = get_rdata(which);
        if (!hold) begin
            drive_bus(which, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_reset();
        int n; logic fb; logic [7:0] rd;
        issue(5, 1'b0, 1'b1, 8'h3F, 8'h9C, 1'b0, 1'b0, n, fb, rd);
        issue(5, 1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h9C) begin
            miscompares++;
            $display("[TB] FAIL reset_preload: READDATA=%h expected %h", rd, 8'h9C);
        end
        @(negedge clk);
        drive_bus(5, 1'b1, 1'b0, 8'h3F, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus5.READDATA !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_readdata: READDATA=%h expected %h", bus5.READDATA, 8'h00);
        end
        vectors++;
        if (bus5.BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busywait: BUSYWAIT=%b expected 0", bus5.BUSYWAIT);
        end
        @(negedge clk);
        drive_bus(5, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        issue(5, 1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h00 || n != 5) begin
            miscompares++;
            $display("[TB] FAIL reset_readback: READDATA=%h busy=%0d expected %h busy=5", rd, n, 8'h00);
        end
    endtask

    task automatic test_write_read();
        int n; logic fb; logic [7:0] rd;
        issue(5, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (fb !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_request_cycle: BUSYWAIT=%b expected 1", fb);
        end
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("[TB] FAIL write_busy_len: busy=%0d expected 5", n);
        end
        issue(5, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'hA5 || n != 5) begin
            miscompares++;
            $display("[TB] FAIL read_after_write: READDATA=%h busy=%0d expected %h busy=5", rd, n, 8'hA5);
        end
        issue(5, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL readdata_hold_on_write: READDATA=%h expected %h", rd, 8'hA5);
        end
    endtask

    task automatic test_hold_through_done();
        int n; logic fb; logic [7:0] rd;
        issue(5, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h3C || n != 5) begin
            miscompares++;
            $display("[TB] FAIL hold_first_access: READDATA=%h busy=%0d expected %h busy=5", rd, n, 8'h3C);
        end
        @(negedge clk);
        #1;
        n = 0;
        while (bus5.BUSYWAIT === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        drive_bus(5, 1'b0, 1'b0, 8'h00, 8'h00);
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("[TB] FAIL hold_second_from_idle: busy=%0d expected 5", n);
        end
    endtask

    task automatic test_read_write_both();
        int n; logic fb; logic [7:0] rd;
        issue(5, 1'b0, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0, n, fb, rd);
        issue(5, 1'b1, 1'b1, 8'h20, 8'h77, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h11) begin
            miscompares++;
            $display("[TB] FAIL both_reads: READDATA=%h expected %h", rd, 8'h11);
        end
        issue(5, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h11) begin
            miscompares++;
            $display("[TB] FAIL both_no_write: READDATA=%h expected %h", rd, 8'h11);
        end
    endtask

    task automatic test_reset_mid_write();
        int n; logic fb; logic [7:0] rd;
        @(negedge clk);
        drive_bus(5, 1'b0, 1'b1, 8'h30, 8'hCC);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus5.BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midwrite_busywait: BUSYWAIT=%b expected 0", bus5.BUSYWAIT);
        end
        @(negedge clk);
        drive_bus(5, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        issue(5, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (n != 5 || fb !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midwrite_idle: busy=%0d first=%b expected busy=5 first=1", n, fb);
        end
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midwrite_aborted: READDATA=%h expected %h", rd, 8'h00);
        end
    endtask

    task automatic test_inputs_toggled(input int which, input int lat);
        int n; logic fb; logic [7:0] rd;
        issue(which, 1'b0, 1'b1, 8'h40, 8'h5A, 1'b0, 1'b1, n, fb, rd);
        vectors++;
        if (n != lat) begin
            miscompares++;
            $display("[TB] FAIL toggle_busy_len_l%0d: busy=%0d expected %0d", lat, n, lat);
        end
        issue(which, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL toggle_mem40_l%0d: READDATA=%h expected %h", lat, rd, 8'h5A);
        end
        issue(which, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, n, fb, rd);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL toggle_memFF_l%0d: READDATA=%h expected %h", lat, rd, 8'h00);
        end
    endtask

    // Scenario sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive_bus(5, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_bus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_write_read();
        test_hold_through_done();
        test_read_write_both();
        test_reset_mid_write();
        test_inputs_toggled(5, 5);
        test_inputs_toggled(1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
